// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//
// Architectural register file with per-register rename tags for the
// out-of-order RISC-V core.
//
// Each architectural register x1..x31 holds a committed 32-bit value and a
// rename tag naming the ROB entry that will produce its next value. A tag
// is {1'b1, rob index} when a producer is in flight; all-zero means the
// value is final. x0 is hard-wired: never written, never tagged.
//
// Update rules, all gated by rdy, taking effect at the rising clock edge:
//   - commit : val[rd] takes the committed value; the tag is freed only if
//              it still names the committing entry (otherwise a younger
//              producer owns the register).
//   - issue  : tag[rd] takes the new tag. Beats a same-cycle tag free.
//   - clr    : rollback. Every tag is freed and any issue is dropped.
//              A same-cycle commit still writes its value.
//
// Read ports are combinational and see the state from before this cycle's
// issue, so a renamed instruction resolves its sources against the old
// mapping. A commit that frees a queried register is bypassed straight to
// the reader so the freed ROB slot never escapes as a tag.
//
// Ports
//   clk                    in   core clock, rising edge
//   rst                    in   asynchronous active-high reset
//   rdy                    in   global enable; low freezes all state
//   clr                    in   rollback: clear every tag
//   issue_to_reg_enable    in   an instruction is renamed this cycle
//   issue_to_reg_rd        in   its destination register
//   issue_to_reg_rob_pos   in   its tag {1'b1, rob index}
//   rob_to_reg_enable      in   a commit writes a register this cycle
//   rob_to_reg_rd          in   committed destination register
//   rob_to_reg_val         in   committed value
//   commit_rob_pos         in   tag of the committing entry (0 if none)
//   dc_to_reg_rs1_pos      in   decoder source register 1
//   dc_to_reg_rs2_pos      in   decoder source register 2
//   reg_to_dc_rs1_val      out  value for rs1
//   reg_to_dc_rs2_val      out  value for rs2
//   reg_to_dc_rs1_rob_pos  out  producing tag for rs1, 0 if value is final
//   reg_to_dc_rs2_rob_pos  out  producing tag for rs2, 0 if value is final
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int ROB_POS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clr,

    input  logic                     issue_to_reg_enable,
    input  logic [4:0]               issue_to_reg_rd,
    input  logic [ROB_POS_WIDTH:0]   issue_to_reg_rob_pos,

    input  logic                     rob_to_reg_enable,
    input  logic [4:0]               rob_to_reg_rd,
    input  logic [31:0]              rob_to_reg_val,
    input  logic [ROB_POS_WIDTH:0]   commit_rob_pos,

    input  logic [4:0]               dc_to_reg_rs1_pos,
    input  logic [4:0]               dc_to_reg_rs2_pos,
    output logic [31:0]              reg_to_dc_rs1_val,
    output logic [31:0]              reg_to_dc_rs2_val,
    output logic [ROB_POS_WIDTH:0]   reg_to_dc_rs1_rob_pos,
    output logic [ROB_POS_WIDTH:0]   reg_to_dc_rs2_rob_pos
);

    localparam int TAG_W    = ROB_POS_WIDTH + 1;
    localparam int NUM_REGS = 32;

    logic [31:0]      val [NUM_REGS];
    logic [TAG_W-1:0] tag [NUM_REGS];

    // One-hot write selects. x0 is excluded here so it can never be
    // written or tagged, and issue is masked by rollback.
    logic [NUM_REGS-1:0] commit_sel;
    logic [NUM_REGS-1:0] issue_sel;

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no
        // path through the block leaves it unassigned and no latch forms.
        commit_sel = '0;
        issue_sel  = '0;
        if (rob_to_reg_enable && rob_to_reg_rd != 5'd0)
            commit_sel[rob_to_reg_rd] = 1'b1;
        if (issue_to_reg_enable && !clr && issue_to_reg_rd != 5'd0)
            issue_sel[issue_to_reg_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the arrays are reset element by element because reads
            // must return 0/0 for every register straight out of reset; this
            // keeps them in flops rather than a RAM macro, which has no reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
        end else if (rdy) begin
            // Entry 0 is left out of the update loop: it keeps its reset
            // value forever.
            for (int i = 1; i < NUM_REGS; i++) begin
                // NOTE: non-blocking assignments, so every comparison below
                // (tag[i] == commit_rob_pos) sees the pre-edge state.
                if (commit_sel[i])
                    val[i] <= rob_to_reg_val;

                // Priority: new rename > rollback > freeing by commit.
                if (issue_sel[i])
                    tag[i] <= issue_to_reg_rob_pos;
                else if (clr)
                    tag[i] <= '0;
                else if (commit_sel[i] && tag[i] == commit_rob_pos)
                    tag[i] <= '0;
            end
        end
    end

    // Two identical read ports. Each returns the stored value/tag, unless
    // the register is being committed right now by the entry it waits on,
    // in which case the committed value is forwarded with a cleared tag.
    for (genvar p = 0; p < 2; p++) begin : g_read
        logic [4:0]       pos;
        logic             bypass;
        logic [31:0]      rd_val;
        logic [TAG_W-1:0] rd_tag;

        assign pos = (p == 0) ? dc_to_reg_rs1_pos : dc_to_reg_rs2_pos;

        assign bypass = rob_to_reg_enable
                     && rob_to_reg_rd == pos
                     && tag[pos] == commit_rob_pos;

        always_comb begin
            rd_val = '0;
            rd_tag = '0;
            if (pos != 5'd0) begin
                if (bypass) begin
                    rd_val = rob_to_reg_val;
                end else begin
                    rd_val = val[pos];
                    rd_tag = tag[pos];
                end
            end
        end
    end

    assign reg_to_dc_rs1_val     = g_read[0].rd_val;
    assign reg_to_dc_rs1_rob_pos = g_read[0].rd_tag;
    assign reg_to_dc_rs2_val     = g_read[1].rd_val;
    assign reg_to_dc_rs2_rob_pos = g_read[1].rd_tag;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//
// Directed scenarios plus a randomized run against a behavioural model.
// Each scenario drives inputs just after a rising edge and pushes the read
// results it expects for that cycle onto a scoreboard queue; a monitor
// pops and compares them on the following falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reg_file;

    localparam int RW = 4;
    localparam int TW = RW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          clr = 1'b0;
    logic          iss_en = 1'b0;
    logic [4:0]    iss_rd = '0;
    logic [TW-1:0] iss_pos = '0;
    logic          cm_en = 1'b0;
    logic [4:0]    cm_rd = '0;
    logic [31:0]   cm_val = '0;
    logic [TW-1:0] cm_pos = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [31:0]   rs1_val, rs2_val;
    logic [TW-1:0] rs1_tag, rs2_tag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        logic [31:0]   v1;
        logic [TW-1:0] t1;
        logic [31:0]   v2;
        logic [TW-1:0] t2;
    } exp_t;

    exp_t sb[$];

    // Behavioural model used by the randomized scenario.
    logic [31:0]   mval [32];
    logic [TW-1:0] mtag [32];

    reg_file #(.ROB_POS_WIDTH(RW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .clr                   (clr),
        .issue_to_reg_enable   (iss_en),
        .issue_to_reg_rd       (iss_rd),
        .issue_to_reg_rob_pos  (iss_pos),
        .rob_to_reg_enable     (cm_en),
        .rob_to_reg_rd         (cm_rd),
        .rob_to_reg_val        (cm_val),
        .commit_rob_pos        (cm_pos),
        .dc_to_reg_rs1_pos     (rs1),
        .dc_to_reg_rs2_pos     (rs2),
        .reg_to_dc_rs1_val     (rs1_val),
        .reg_to_dc_rs2_val     (rs2_val),
        .reg_to_dc_rs1_rob_pos (rs1_tag),
        .reg_to_dc_rs2_rob_pos (rs2_tag)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: everything queued in this cycle is compared at
    // the falling edge, well away from the rising edge.
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rs1_val !== e.v1 || rs1_tag !== e.t1) begin
                failures++;
                $display("FAIL %s rs1=%0d: got %h/%h expected %h/%h",
                         e.name, rs1, rs1_val, rs1_tag, e.v1, e.t1);
            end
            checks++;
            if (rs2_val !== e.v2 || rs2_tag !== e.t2) begin
                failures++;
                $display("FAIL %s rs2=%0d: got %h/%h expected %h/%h",
                         e.name, rs2, rs2_val, rs2_tag, e.v2, e.t2);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy    = 1'b1;
        clr    = 1'b0;
        iss_en = 1'b0;
        cm_en  = 1'b0;
        cm_pos = '0;
    endtask

    task automatic expect_rd(input string name,
                             input logic [31:0] v1, input logic [TW-1:0] t1,
                             input logic [31:0] v2, input logic [TW-1:0] t2);
        exp_t e;
        e.name = name; e.v1 = v1; e.t1 = t1; e.v2 = v2; e.t2 = t2;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) next_cycle();
        rst = 1'b0;
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        checks++;
        if (rs1_val !== 32'd0 || rs1_tag !== '0) begin
            failures++;
            $display("FAIL reset_x5: got %h/%h expected 0/0", rs1_val, rs1_tag);
        end
        expect_rd("reset_query", 32'd0, 5'h00, 32'd0, 5'h00);
        next_cycle();
    endtask

    task automatic test_x0();
        idle();
        iss_en = 1'b1; iss_rd = 5'd0; iss_pos = 5'h11;
        cm_en = 1'b1; cm_rd = 5'd0; cm_val = 32'hFFFF_FFFF; cm_pos = 5'h00;
        rs1 = 5'd0; rs2 = 5'd0;
        expect_rd("x0_write_cycle", 32'd0, 5'h00, 32'd0, 5'h00);
        next_cycle();
        idle();
        rs1 = 5'd0; rs2 = 5'd5;
        expect_rd("x0_after_write", 32'd0, 5'h00, 32'd0, 5'h00);
        next_cycle();
    endtask

    task automatic test_commit_bypass();
        idle();
        iss_en = 1'b1; iss_rd = 5'd5; iss_pos = 5'h13;
        rs1 = 5'd5; rs2 = 5'd0;
        // Same-cycle issue is invisible to reads.
        expect_rd("issue_not_visible", 32'd0, 5'h00, 32'd0, 5'h00);
        next_cycle();
        idle();
        expect_rd("tag_after_issue", 32'd0, 5'h13, 32'd0, 5'h00);
        next_cycle();
        cm_en = 1'b1; cm_rd = 5'd5; cm_val = 32'hDEAD_BEEF; cm_pos = 5'h13;
        rs2 = 5'd5;
        expect_rd("commit_bypass", 32'hDEAD_BEEF, 5'h00, 32'hDEAD_BEEF, 5'h00);
        next_cycle();
        idle();
        expect_rd("after_commit", 32'hDEAD_BEEF, 5'h00, 32'hDEAD_BEEF, 5'h00);
        next_cycle();
    endtask

    task automatic test_younger_producer();
        idle();
        iss_en = 1'b1; iss_rd = 5'd7; iss_pos = 5'h10;
        next_cycle();
        iss_pos = 5'h12;
        rs1 = 5'd7; rs2 = 5'd5;
        expect_rd("rename_twice", 32'd0, 5'h10, 32'hDEAD_BEEF, 5'h00);
        next_cycle();
        idle();
        cm_en = 1'b1; cm_rd = 5'd7; cm_val = 32'd1; cm_pos = 5'h10;
        expect_rd("old_commit_no_bypass", 32'd0, 5'h12, 32'hDEAD_BEEF, 5'h00);
        next_cycle();
        idle();
        expect_rd("young_tag_kept", 32'd1, 5'h12, 32'hDEAD_BEEF, 5'h00);
        next_cycle();
    endtask

    task automatic test_same_cycle();
        idle();
        iss_en = 1'b1; iss_rd = 5'd3; iss_pos = 5'h11;
        next_cycle();
        iss_pos = 5'h14;
        cm_en = 1'b1; cm_rd = 5'd3; cm_val = 32'd9; cm_pos = 5'h11;
        rs1 = 5'd3; rs2 = 5'd7;
        expect_rd("same_cycle_bypass", 32'd9, 5'h00, 32'd1, 5'h12);
        next_cycle();
        idle();
        expect_rd("issue_beats_free", 32'd9, 5'h14, 32'd1, 5'h12);
        next_cycle();
    endtask

    task automatic test_clr();
        idle();
        for (int r = 1; r <= 4; r++) begin
            iss_en = 1'b1; iss_rd = 5'(r); iss_pos = 5'(5'h14 + r);
            next_cycle();
        end
        idle();
        rs1 = 5'd2; rs2 = 5'd4;
        expect_rd("tags_before_clr", 32'd0, 5'h16, 32'd0, 5'h18);
        next_cycle();
        clr = 1'b1;
        cm_en = 1'b1; cm_rd = 5'd2; cm_val = 32'h55; cm_pos = 5'h1F;
        iss_en = 1'b1; iss_rd = 5'd6; iss_pos = 5'h19;
        rs1 = 5'd2; rs2 = 5'd6;
        expect_rd("clr_cycle", 32'd0, 5'h16, 32'd0, 5'h00);
        next_cycle();
        idle();
        expect_rd("clr_value_kept", 32'h55, 5'h00, 32'd0, 5'h00);
        next_cycle();
        rs1 = 5'd1; rs2 = 5'd7;
        expect_rd("clr_all_tags", 32'd0, 5'h00, 32'd1, 5'h00);
        next_cycle();
        rs1 = 5'd3; rs2 = 5'd4;
        expect_rd("clr_all_tags2", 32'd9, 5'h00, 32'd0, 5'h00);
        next_cycle();
    endtask

    task automatic test_rdy_freeze();
        idle();
        iss_en = 1'b1; iss_rd = 5'd9; iss_pos = 5'h1A;
        next_cycle();
        rdy = 1'b0;
        clr = 1'b1;
        iss_en = 1'b1; iss_rd = 5'd8; iss_pos = 5'h1B;
        cm_en = 1'b1; cm_rd = 5'd9; cm_val = 32'h123; cm_pos = 5'h1A;
        rs1 = 5'd8; rs2 = 5'd9;
        // Bypass still follows the inputs while frozen.
        expect_rd("frozen_cycle", 32'd0, 5'h00, 32'h123, 5'h00);
        next_cycle();
        idle();
        expect_rd("frozen_no_change", 32'd0, 5'h00, 32'd0, 5'h1A);
        next_cycle();
    endtask

    task automatic test_async_reset();
        idle();
        rs1 = 5'd5; rs2 = 5'd9;
        expect_rd("pre_async_reset", 32'hDEAD_BEEF, 5'h00, 32'd0, 5'h1A);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rs1_val !== 32'd0 || rs1_tag !== '0 || rs2_val !== 32'd0 || rs2_tag !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h/%h %h/%h expected all 0",
                     rs1_val, rs1_tag, rs2_val, rs2_tag);
        end
        rst = 1'b0;
        next_cycle();
        expect_rd("after_async_reset", 32'd0, 5'h00, 32'd0, 5'h00);
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0]   ev1, ev2;
        logic [TW-1:0] et1, et2;
        for (int r = 0; r < 32; r++) begin
            mval[r] = '0;
            mtag[r] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            rdy     = ($urandom_range(0, 9) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            iss_en  = $urandom_range(0, 1) == 1;
            iss_rd  = 5'($urandom_range(0, 7));
            iss_pos = {1'b1, 4'($urandom_range(0, 15))};
            cm_en   = $urandom_range(0, 1) == 1;
            cm_rd   = 5'($urandom_range(0, 7));
            cm_val  = $urandom;
            if ($urandom_range(0, 1) == 1 && mtag[cm_rd] != '0)
                cm_pos = mtag[cm_rd];
            else
                cm_pos = {1'b1, 4'($urandom_range(0, 15))};
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));

            ev1 = '0; et1 = '0;
            if (rs1 != 0) begin
                if (cm_en && cm_rd == rs1 && mtag[rs1] == cm_pos) ev1 = cm_val;
                else begin ev1 = mval[rs1]; et1 = mtag[rs1]; end
            end
            ev2 = '0; et2 = '0;
            if (rs2 != 0) begin
                if (cm_en && cm_rd == rs2 && mtag[rs2] == cm_pos) ev2 = cm_val;
                else begin ev2 = mval[rs2]; et2 = mtag[rs2]; end
            end
            expect_rd("random", ev1, et1, ev2, et2);

            if (rdy) begin
                if (cm_en && cm_rd != 0) begin
                    mval[cm_rd] = cm_val;
                    if (mtag[cm_rd] == cm_pos) mtag[cm_rd] = '0;
                end
                if (clr) begin
                    for (int r = 0; r < 32; r++) mtag[r] = '0;
                end else if (iss_en && iss_rd != 0) begin
                    mtag[iss_rd] = iss_pos;
                end
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_x0();
        test_commit_bypass();
        test_younger_producer();
        test_same_cycle();
        test_clr();
        test_rdy_freeze();
        test_async_reset();
        test_random();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
